// File: rtl/ram_types_pkg.sv
// Shared types for the RAM bus responder and its storage array.
// Holds the bus status encoding and the word type.
package ram_types_pkg;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/ram_array.sv
// DEPTH x 32 storage: one sync write port (backdoor beats bus), one sync read.
// Ports: CLK, rst (read register only), we/waddr/wdata, load_*, re/raddr, rdata.
module ram_array
  import ram_types_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  word_t         wdata,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  word_t         load_data,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output word_t         rdata
);

  word_t mem [DEPTH];

  // The later assignment wins on an index collision, so the backdoor
  // takes priority over the bus.
  always_ff @(posedge CLK) begin
    if (we)
      mem[waddr] <= wdata;
    if (load_en)
      mem[load_addr] <= load_data;
  end

  // Read register holds its value until the next bus read.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst)
      rdata <= '0;
    else if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_responder.sv
// Memory end of the core RAM bus: one word access per request after LAT
// busy cycles. Ports: CLK, rst, mem* request, ramload/ramstate, load_* backdoor.
module ram_responder
  import ram_types_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic [31:0]   memaddr,
  input  logic [31:0]   memstore,
  input  logic          memREN,
  input  logic          memWEN,
  output logic [31:0]   ramload,
  output ramstate_t     ramstate,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data
);

  localparam logic [3:0] RELOAD =
    (LAT > 0) ? 4'(LAT - 1) : 4'd0;
  localparam logic [29:0] LIMIT = 30'(DEPTH);

  ramstate_t   state;
  logic [3:0]  cnt;
  logic [31:0] laddr;
  logic        lwr;

  logic req;
  logic valid;
  logic changed;
  logic fire;

  assign req = memREN | memWEN;

  // Full-width range check so high address bits never alias.
  assign valid = (memREN ^ memWEN)
              && (memaddr[1:0] == 2'b00)
              && (memaddr[31:2] < LIMIT);

  assign changed = (memaddr != laddr)
                || (memWEN != lwr);

  // Edge on which the FSM enters ACCESS; the array acts on it.
  assign fire = valid && (
      (state == FREE && LAT == 0)
   || (state == BUSY && !changed && cnt == 4'd0));

  assign ramstate = state;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state <= FREE;
      cnt   <= '0;
      laddr <= '0;
      lwr   <= 1'b0;
    end else begin
      unique case (state)
        FREE: begin
          if (req) begin
            if (!valid) begin
              state <= ERROR;
            end else begin
              laddr <= memaddr;
              lwr   <= memWEN;
              if (LAT == 0) begin
                state <= ACCESS;
              end else begin
                state <= BUSY;
                cnt   <= RELOAD;
              end
            end
          end
        end
        BUSY: begin
          if (!req) begin
            state <= FREE;
          end else if (!valid) begin
            state <= ERROR;
          end else if (changed) begin
            laddr <= memaddr;
            lwr   <= memWEN;
            cnt   <= RELOAD;
          end else if (cnt == 4'd0) begin
            state <= ACCESS;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACCESS: state <= FREE;
        ERROR:  state <= FREE;
      endcase
    end
  end

  ram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .CLK       (CLK),
    .rst       (rst),
    .we        (fire & memWEN),
    .waddr     (memaddr[AW+1:2]),
    .wdata     (memstore),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .re        (fire & memREN),
    .raddr     (memaddr[AW+1:2]),
    .rdata     (ramload)
  );

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder at LAT 0, 2 and 3.
// Instances share clock and reset; each has its own bus.
module tb_ram_responder;
  import ram_types_pkg::*;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr  [3];
  logic [31:0] store [3];
  logic        ren   [3];
  logic        wen   [3];
  logic        len   [3];
  logic [9:0]  ladr  [3];
  logic [31:0] ldat  [3];
  logic [31:0] load  [3];
  ramstate_t   st    [3];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ram_responder #(.LAT(0)) d0 (
    .CLK(CLK), .rst(rst), .memaddr(addr[0]), .memstore(store[0]),
    .memREN(ren[0]), .memWEN(wen[0]), .ramload(load[0]),
    .ramstate(st[0]), .load_en(len[0]), .load_addr(ladr[0]),
    .load_data(ldat[0]));

  ram_responder #(.LAT(2)) d2 (
    .CLK(CLK), .rst(rst), .memaddr(addr[1]), .memstore(store[1]),
    .memREN(ren[1]), .memWEN(wen[1]), .ramload(load[1]),
    .ramstate(st[1]), .load_en(len[1]), .load_addr(ladr[1]),
    .load_data(ldat[1]));

  ram_responder #(.LAT(3)) d3 (
    .CLK(CLK), .rst(rst), .memaddr(addr[2]), .memstore(store[2]),
    .memREN(ren[2]), .memWEN(wen[2]), .ramload(load[2]),
    .ramstate(st[2]), .load_en(len[2]), .load_addr(ladr[2]),
    .load_data(ldat[2]));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bdoor(input int i, input logic [9:0] a,
                       input logic [31:0] d);
    len[i]  = 1'b1;
    ladr[i] = a;
    ldat[i] = d;
    tick();
    len[i] = 1'b0;
  endtask

  // Runs one bus transaction (bounded wait), reports final status
  // and ramload; comparisons are done by the caller.
  task automatic bus_op(input int i, input logic [31:0] a,
                        input logic w, input logic [31:0] d,
                        output logic [31:0] rd,
                        output ramstate_t fin);
    addr[i]  = a;
    store[i] = d;
    ren[i]   = !w;
    wen[i]   = w;
    fin      = FREE;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (st[i] == ACCESS || st[i] == ERROR) begin
        fin = st[i];
        break;
      end
    end
    rd     = load[i];
    ren[i] = 1'b0;
    wen[i] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr[i] = '0; store[i] = '0; ren[i] = 0; wen[i] = 0;
      len[i] = 0; ladr[i] = '0; ldat[i] = '0;
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (st[i] !== FREE || load[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset[%0d] got %s/%h want FREE/0",
                 i, st[i].name(), load[i]);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_lat2();
    ramstate_t exp [4];
    exp = '{BUSY, BUSY, ACCESS, FREE};
    bdoor(1, 10'd5, 32'hDEADBEEF);
    addr[1] = 32'h14;
    ren[1]  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (st[1] !== exp[c]) begin
        errors++;
        $display("FAIL lat2_cycle%0d got %s want %s",
                 c + 1, st[1].name(), exp[c].name());
      end
      if (exp[c] == ACCESS) begin
        checks++;
        if (load[1] !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL lat2_data got %h want deadbeef", load[1]);
        end
        ren[1] = 1'b0;
      end
    end
  endtask

  task automatic test_lat0();
    addr[0]  = 32'h40;
    store[0] = 32'h12345678;
    wen[0]   = 1'b1;
    tick();
    checks++;
    if (st[0] !== ACCESS) begin
      errors++;
      $display("FAIL lat0_wr got %s want ACCESS", st[0].name());
    end
    wen[0] = 1'b0;
    tick();
    checks++;
    if (st[0] !== FREE) begin
      errors++;
      $display("FAIL lat0_turn got %s want FREE", st[0].name());
    end
    ren[0] = 1'b1;
    tick();
    checks++;
    if (st[0] !== ACCESS || load[0] !== 32'h12345678) begin
      errors++;
      $display("FAIL lat0_rd got %s/%h want ACCESS/12345678",
               st[0].name(), load[0]);
    end
    ren[0] = 1'b0;
    tick();
  endtask

  task automatic test_malformed();
    logic [31:0] av [3];
    logic [31:0] rd;
    ramstate_t   fin;
    av = '{32'h14, 32'h3, 32'h1000};
    bdoor(1, 10'd0, 32'h11111111);
    for (int m = 0; m < 3; m++) begin
      addr[1]  = av[m];
      store[1] = 32'hBAD0_0000 + m;
      wen[1]   = 1'b1;
      ren[1]   = (m == 0);
      tick();
      checks++;
      if (st[1] !== ERROR || load[1] !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL malformed%0d got %s/%h want ERROR/deadbeef",
                 m, st[1].name(), load[1]);
      end
      ren[1] = 1'b0;
      wen[1] = 1'b0;
      tick();
      checks++;
      if (st[1] !== FREE) begin
        errors++;
        $display("FAIL malformed%0d_free got %s want FREE",
                 m, st[1].name());
      end
    end
    bus_op(1, 32'h14, 1'b0, 32'h0, rd, fin);
    checks++;
    if (fin !== ACCESS || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL malformed_word5 got %s/%h want ACCESS/deadbeef",
               fin.name(), rd);
    end
    bus_op(1, 32'h0, 1'b0, 32'h0, rd, fin);
    checks++;
    if (fin !== ACCESS || rd !== 32'h11111111) begin
      errors++;
      $display("FAIL malformed_word0 got %s/%h want ACCESS/11111111",
               fin.name(), rd);
    end
  endtask

  task automatic test_restart();
    ramstate_t   exp [6];
    logic [31:0] rd;
    ramstate_t   fin;
    exp = '{BUSY, BUSY, BUSY, BUSY, BUSY, ACCESS};
    bdoor(2, 10'd4, 32'h44444444);
    bdoor(2, 10'd8, 32'h88888888);
    bdoor(2, 10'd12, 32'hC0C0C0C0);
    addr[2] = 32'h10;
    ren[2]  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (st[2] !== exp[c]) begin
        errors++;
        $display("FAIL restart_cycle%0d got %s want %s",
                 c + 1, st[2].name(), exp[c].name());
      end
      if (c == 1)
        addr[2] = 32'h20;
    end
    checks++;
    if (load[2] !== 32'h88888888) begin
      errors++;
      $display("FAIL restart_data got %h want 88888888", load[2]);
    end
    ren[2] = 1'b0;
    tick();
    addr[2]  = 32'h30;
    store[2] = 32'hFFFF0000;
    wen[2]   = 1'b1;
    tick();
    tick();
    wen[2] = 1'b0;
    tick();
    checks++;
    if (st[2] !== FREE) begin
      errors++;
      $display("FAIL abort got %s want FREE", st[2].name());
    end
    bus_op(2, 32'h30, 1'b0, 32'h0, rd, fin);
    checks++;
    if (fin !== ACCESS || rd !== 32'hC0C0C0C0) begin
      errors++;
      $display("FAIL abort_nowrite got %s/%h want ACCESS/c0c0c0c0",
               fin.name(), rd);
    end
  endtask

  task automatic test_hold();
    ramstate_t exp;
    ramstate_t prev;
    prev    = FREE;
    addr[1] = 32'h14;
    ren[1]  = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      case (c % 4)
        3:       exp = ACCESS;
        0:       exp = FREE;
        default: exp = BUSY;
      endcase
      checks++;
      if (st[1] !== exp || (prev == ACCESS && st[1] == ACCESS)) begin
        errors++;
        $display("FAIL hold_cycle%0d got %s want %s",
                 c, st[1].name(), exp.name());
      end
      prev = st[1];
    end
    ren[1] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    ramstate_t   fin;
    bdoor(1, 10'd2, 32'hA);
    addr[1]  = 32'h8;
    store[1] = 32'h55555555;
    wen[1]   = 1'b1;
    tick();
    checks++;
    if (st[1] !== BUSY || load[1] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rstmid_pre got %s/%h want BUSY/deadbeef",
               st[1].name(), load[1]);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (st[1] !== FREE || load[1] !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_async got %s/%h want FREE/0",
               st[1].name(), load[1]);
    end
    wen[1] = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    bus_op(1, 32'h8, 1'b0, 32'h0, rd, fin);
    checks++;
    if (fin !== ACCESS || rd !== 32'hA) begin
      errors++;
      $display("FAIL rstmid_keep got %s/%h want ACCESS/0000000a",
               fin.name(), rd);
    end
  endtask

  task automatic test_backdoor_prio();
    logic [31:0] rd;
    ramstate_t   fin;
    addr[0]  = 32'h50;
    store[0] = 32'h11110000;
    wen[0]   = 1'b1;
    len[0]   = 1'b1;
    ladr[0]  = 10'd20;
    ldat[0]  = 32'h22220000;
    tick();
    checks++;
    if (st[0] !== ACCESS) begin
      errors++;
      $display("FAIL prio_wr got %s want ACCESS", st[0].name());
    end
    wen[0] = 1'b0;
    len[0] = 1'b0;
    tick();
    bus_op(0, 32'h50, 1'b0, 32'h0, rd, fin);
    checks++;
    if (fin !== ACCESS || rd !== 32'h22220000) begin
      errors++;
      $display("FAIL prio_rd got %s/%h want ACCESS/22220000",
               fin.name(), rd);
    end
  endtask

  initial begin
    test_reset();
    test_read_lat2();
    test_lat0();
    test_malformed();
    test_restart();
    test_hold();
    test_reset_mid();
    test_backdoor_prio();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
